// File: rtl/nvram_upload_ctrl_if.sv
// hps_io ioctl upload bus between hps_io (master) and the NVRAM upload
// controller (slave). The controller answers reads and can ask for an upload.
interface nvram_upload_ctrl_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_wait,
        input  ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_wait,
        output ioctl_upload_req
    );
endinterface

// File: rtl/nvram_upload_ctrl.sv
// NVRAM upload controller: serves HPS byte reads during an ioctl upload from
// the second read port of the on-core NVRAM, and raises ioctl_upload_req when
// the core or OSD asks for a save. Addresses at or beyond SIZE read as 8'hFF
// without touching the RAM.
module nvram_upload_ctrl #(
    parameter logic [7:0]  INDEX       = 8'd4,
    parameter int          ADDR_W      = 10,
    parameter int          SIZE        = 1024,
    parameter int          RAM_LAT     = 2,
    parameter logic [23:0] REQ_TIMEOUT = 24'd5_360_000
) (
    input  logic               i_clk,
    input  logic               RESETn,
    input  logic               save_req,
    nvram_upload_ctrl_if.slave ioctl,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_rd,
    input  logic [7:0]         ram_q,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVE,
        FETCH
    } state_t;

    localparam logic [24:0] SIZE_W   = 25'(SIZE);
    localparam logic [23:0] REQ_LAST = REQ_TIMEOUT - 24'd1;
    localparam logic [2:0]  LAT_LAST = 3'(RAM_LAT);

    state_t            state, state_n;
    logic              save_q;
    logic [23:0]       req_cnt, req_cnt_n;
    logic [2:0]        lat_cnt, lat_cnt_n;
    logic              in_range, in_range_n;
    logic [7:0]        din_q, din_n;
    logic              wait_q, wait_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic              ram_rd_n;
    logic              done_n;
    logic              timeout_n;
    logic              sel;
    logic              save_rise;
    logic              addr_ok;

    assign sel       = ioctl.ioctl_upload && (ioctl.ioctl_index == INDEX);
    assign save_rise = save_req && !save_q;
    assign addr_ok   = (ioctl.ioctl_addr < SIZE_W);

    assign ioctl.ioctl_din        = din_q;
    assign ioctl.ioctl_wait       = wait_q;
    assign ioctl.ioctl_upload_req = (state == REQ);
    assign busy                   = (state != IDLE);

    // Register the FSM state, counters, save_req history and all registered outputs.
    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            save_q   <= 1'b0;
            req_cnt  <= '0;
            lat_cnt  <= '0;
            in_range <= 1'b0;
            din_q    <= 8'h00;
            wait_q   <= 1'b0;
            ram_addr <= '0;
            ram_rd   <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            save_q   <= save_req;
            req_cnt  <= req_cnt_n;
            lat_cnt  <= lat_cnt_n;
            in_range <= in_range_n;
            din_q    <= din_n;
            wait_q   <= wait_n;
            ram_addr <= ram_addr_n;
            ram_rd   <= ram_rd_n;
            done     <= done_n;
            timeout  <= timeout_n;
        end
    end

    // Next-state logic; a selected upload always takes priority over a save request,
    // and a fetch always runs to completion before sel is looked at again.
    always_comb begin
        state_n    = state;
        req_cnt_n  = req_cnt;
        lat_cnt_n  = lat_cnt;
        in_range_n = in_range;
        din_n      = din_q;
        wait_n     = wait_q;
        ram_addr_n = ram_addr;
        ram_rd_n   = 1'b0;
        done_n     = 1'b0;
        timeout_n  = 1'b0;
        case (state)
            IDLE: begin
                if (sel) begin
                    state_n = SERVE;
                end else if (save_rise) begin
                    state_n   = REQ;
                    req_cnt_n = '0;
                end
            end
            REQ: begin
                if (sel) begin
                    state_n = SERVE;
                end else if (req_cnt == REQ_LAST) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end else begin
                    req_cnt_n = req_cnt + 24'd1;
                end
            end
            SERVE: begin
                if (!sel) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (ioctl.ioctl_rd) begin
                    state_n    = FETCH;
                    wait_n     = 1'b1;
                    lat_cnt_n  = '0;
                    in_range_n = addr_ok;
                    if (addr_ok) begin
                        ram_addr_n = ioctl.ioctl_addr[ADDR_W-1:0];
                        ram_rd_n   = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (lat_cnt == LAT_LAST) begin
                    din_n   = in_range ? ram_q : 8'hFF;
                    wait_n  = 1'b0;
                    state_n = SERVE;
                end else begin
                    lat_cnt_n = lat_cnt + 3'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Bench for nvram_upload_ctrl: the main process drives hps_io-style reads and
// pushes the expected response into a scoreboard queue; a monitor pops and
// checks on every falling edge of ioctl_wait. The RAM is modelled by the bench.
`timescale 1ns/1ps
module tb_nvram_upload_ctrl;

    localparam int         ADDR_W  = 10;
    localparam int         SIZE    = 1024;
    localparam int         RAM_LAT = 2;
    localparam logic [7:0] INDEX   = 8'd4;
    localparam int         REQ_TO  = 16;

    typedef struct {
        logic [7:0] data;
        int         ram_rds;
    } exp_t;

    logic              i_clk = 1'b0;
    logic              RESETn = 1'b0;
    logic              save_req = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_q;
    logic              busy;
    logic              done;
    logic              timeout;

    nvram_upload_ctrl_if bus ();

    nvram_upload_ctrl #(
        .INDEX       (INDEX),
        .ADDR_W      (ADDR_W),
        .SIZE        (SIZE),
        .RAM_LAT     (RAM_LAT),
        .REQ_TIMEOUT (24'(REQ_TO))
    ) dut (
        .i_clk    (i_clk),
        .RESETn   (RESETn),
        .save_req (save_req),
        .ioctl    (bus),
        .ram_addr (ram_addr),
        .ram_rd   (ram_rd),
        .ram_q    (ram_q),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] mem [SIZE];
    logic [7:0] pipe_data [RAM_LAT] = '{default: 8'h00};
    logic       pipe_valid [RAM_LAT] = '{default: 1'b0};
    logic [7:0] junk = 8'h00;

    exp_t exp_q [$];
    exp_t mon_exp;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_count = 0;
    int   timeout_count = 0;
    int   ram_rd_total = 0;

    // RAM with RAM_LAT cycles of read latency; ram_q carries junk outside the valid cycle.
    always @(posedge i_clk) begin
        junk          <= 8'($urandom);
        pipe_valid[0] <= ram_rd;
        pipe_data[0]  <= mem[ram_addr];
        for (int i = 1; i < RAM_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
        end
    end

    assign ram_q = pipe_valid[RAM_LAT-1] ? pipe_data[RAM_LAT-1] : junk;

    // Reference rule: in-range bytes come from memory, everything else reads as FF.
    function automatic logic [7:0] ref_read(input logic [24:0] a);
        return (a < 25'(SIZE)) ? mem[a[ADDR_W-1:0]] : 8'hFF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Wait (bounded) until the monitor has consumed every outstanding expectation.
    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("read_never_completed", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    // Issue one read strobe, record the expected result, and wait for it to finish.
    task automatic applyStimulus(input logic [24:0] a);
        exp_t e;
        e.data    = ref_read(a);
        e.ram_rds = (a < 25'(SIZE)) ? 1 : 0;
        @(posedge i_clk);
        #1;
        exp_q.push_back(e);
        bus.ioctl_addr = a;
        bus.ioctl_rd   = 1'b1;
        @(posedge i_clk);
        #1;
        bus.ioctl_rd   = 1'b0;
        bus.ioctl_addr = 25'($urandom);
        wait_drain();
    endtask

    // Monitor: tracks pulses and checks every completed read against the scoreboard.
    initial begin
        logic prev_wait;
        int   wait_cycles;
        int   rd_pulses;
        int   cycle_no;
        int   rd_cycle;
        prev_wait   = 1'b0;
        wait_cycles = 0;
        rd_pulses   = 0;
        cycle_no    = 0;
        rd_cycle    = -1;
        forever begin
            @(negedge i_clk);
            cycle_no++;
            if (!RESETn) begin
                prev_wait   = 1'b0;
                wait_cycles = 0;
                rd_pulses   = 0;
                rd_cycle    = -1;
            end else begin
                if (ram_rd) begin
                    rd_pulses++;
                    ram_rd_total++;
                end
                if (done) done_count++;
                if (timeout) timeout_count++;
                if (bus.ioctl_rd && !bus.ioctl_wait && bus.ioctl_upload &&
                    bus.ioctl_index == INDEX && rd_cycle < 0) begin
                    rd_cycle = cycle_no;
                end
                if (bus.ioctl_wait) wait_cycles++;
                if (prev_wait && !bus.ioctl_wait) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_read_completion", 1, 0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        checkOutput("ioctl_din", 32'(bus.ioctl_din), 32'(mon_exp.data));
                        checkOutput("ram_rd_pulses", 32'(rd_pulses), 32'(mon_exp.ram_rds));
                        checkOutput("wait_high_cycles", 32'(wait_cycles), 32'(RAM_LAT + 1));
                        checkOutput("rd_to_wait_fall", 32'(cycle_no - rd_cycle), 32'(RAM_LAT + 2));
                    end
                    wait_cycles = 0;
                    rd_pulses   = 0;
                    rd_cycle    = -1;
                end
                prev_wait = bus.ioctl_wait;
            end
        end
    end

    // Safety net in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int   n;
        int   snap;
        int   wait_seen;
        exp_t e;

        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'd0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;
        for (int i = 0; i < SIZE; i++) mem[i] = 8'(i) ^ 8'h5A;

        repeat (3) @(negedge i_clk);
        checkOutput("reset_din", 32'(bus.ioctl_din), 0);
        checkOutput("reset_wait", 32'(bus.ioctl_wait), 0);
        checkOutput("reset_upload_req", 32'(bus.ioctl_upload_req), 0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 0);
        checkOutput("reset_ram_rd", 32'(ram_rd), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_timeout", 32'(timeout), 0);
        @(posedge i_clk);
        #1 RESETn = 1'b1;

        // Save request, then the HPS answers with an upload at our index.
        @(posedge i_clk);
        #1 save_req = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("req_after_save_edge", 32'(bus.ioctl_upload_req), 1);
        checkOutput("busy_in_req", 32'(busy), 1);
        @(posedge i_clk);
        #1;
        save_req         = 1'b0;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = INDEX;
        @(negedge i_clk);
        checkOutput("req_held_until_edge", 32'(bus.ioctl_upload_req), 1);
        @(negedge i_clk);
        checkOutput("req_dropped_on_serve", 32'(bus.ioctl_upload_req), 0);
        checkOutput("busy_in_serve", 32'(busy), 1);

        // Directed reads: range edges and out-of-range addresses.
        applyStimulus(25'd0);
        applyStimulus(25'd1);
        applyStimulus(25'd1023);
        applyStimulus(25'd1024);
        applyStimulus(25'h1FFFFFF);

        // Randomised contents and addresses, biased toward the range boundary.
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(25'($urandom));
            else applyStimulus(25'($urandom_range(0, SIZE + 63)));
        end

        // A second strobe while fetching must be ignored.
        e.data    = ref_read(25'd77);
        e.ram_rds = 1;
        @(posedge i_clk);
        #1;
        exp_q.push_back(e);
        bus.ioctl_addr = 25'd77;
        bus.ioctl_rd   = 1'b1;
        @(posedge i_clk);
        #1 bus.ioctl_rd = 1'b0;
        @(posedge i_clk);
        #1;
        bus.ioctl_addr = 25'd300;
        bus.ioctl_rd   = 1'b1;
        @(posedge i_clk);
        #1 bus.ioctl_rd = 1'b0;
        wait_drain();

        // Upload ends mid-read: read completes first, then done pulses once.
        snap      = done_count;
        e.data    = ref_read(25'd500);
        e.ram_rds = 1;
        @(posedge i_clk);
        #1;
        exp_q.push_back(e);
        bus.ioctl_addr = 25'd500;
        bus.ioctl_rd   = 1'b1;
        @(posedge i_clk);
        #1;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_upload = 1'b0;
        wait_drain();
        checkOutput("no_done_before_read_finishes", 32'(done_count - snap), 0);
        repeat (5) @(negedge i_clk);
        checkOutput("done_pulses_after_upload", 32'(done_count - snap), 1);
        checkOutput("busy_after_done", 32'(busy), 0);

        // Unanswered save request times out; a second edge during REQ is ignored.
        snap = timeout_count;
        @(posedge i_clk);
        #1 save_req = 1'b1;
        @(posedge i_clk);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
            if (n == 3) save_req = 1'b0;
            if (n == 6) save_req = 1'b1;
        end while (bus.ioctl_upload_req && n < 100);
        checkOutput("req_high_cycles", 32'(n - 1), 32'(REQ_TO));
        checkOutput("timeout_pulse", 32'(timeout), 1);
        checkOutput("busy_after_timeout", 32'(busy), 0);
        @(negedge i_clk);
        checkOutput("timeout_one_cycle", 32'(timeout), 0);
        save_req = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("timeout_pulse_count", 32'(timeout_count - snap), 1);
        checkOutput("no_req_after_timeout", 32'(bus.ioctl_upload_req), 0);

        // Asynchronous reset while ioctl_wait is high.
        @(posedge i_clk);
        #1;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = INDEX;
        repeat (2) @(posedge i_clk);
        #1;
        bus.ioctl_addr = 25'd5;
        bus.ioctl_rd   = 1'b1;
        @(posedge i_clk);
        #1 bus.ioctl_rd = 1'b0;
        @(negedge i_clk);
        checkOutput("wait_before_reset", 32'(bus.ioctl_wait), 1);
        #2 RESETn = 1'b0;
        #1;
        checkOutput("async_reset_wait", 32'(bus.ioctl_wait), 0);
        checkOutput("async_reset_busy", 32'(busy), 0);
        bus.ioctl_index = 8'd0;
        @(negedge i_clk);
        @(posedge i_clk);
        #1 RESETn = 1'b1;

        // Reads at a foreign index get no response at all.
        snap      = ram_rd_total;
        wait_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            bus.ioctl_addr = 25'($urandom_range(0, SIZE - 1));
            bus.ioctl_rd   = 1'b1;
            @(posedge i_clk);
            #1 bus.ioctl_rd = 1'b0;
            repeat (5) begin
                @(negedge i_clk);
                if (bus.ioctl_wait) wait_seen++;
            end
        end
        checkOutput("foreign_index_wait", 32'(wait_seen), 0);
        checkOutput("foreign_index_ram_rd", 32'(ram_rd_total - snap), 0);
        checkOutput("foreign_index_busy", 32'(busy), 0);
        bus.ioctl_upload = 1'b0;

        repeat (3) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
